// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and defaults for the round-robin keyed request arbiter.
package rr_req_arbiter_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_KEY_W = 4;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
    typedef logic [DEF_KEY_W-1:0] key_t;
endpackage

// File: rtl/rr_req_arbiter_if.sv
// Requester-side and server-side signals of the arbiter bundled as one bus.
interface rr_req_arbiter_if
    import rr_req_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int KEY_W = DEF_KEY_W
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*KEY_W-1:0] req_key;
    logic [N_REQ-1:0]       ack;
    logic                   srv_req;
    logic [KEY_W-1:0]       srv_key;
    logic [ID_W-1:0]        srv_id;
    logic                   srv_ack;
    logic [N_REQ-1:0]       seq_err;

    modport slave  (input  req, req_key, srv_ack,
                    output ack, srv_req, srv_key, srv_id, seq_err);
    modport master (output req, req_key, srv_ack,
                    input  ack, srv_req, srv_key, srv_id, seq_err);
endinterface

// File: rtl/rr_req_arbiter_pick.sv
// Combinational round-robin picker: first unmasked request at or after prio_i.
module rr_pick
    import rr_req_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic [ID_W-1:0]  prio_i,
    output logic             vld_o,
    output logic [ID_W-1:0]  idx_o
);
    always_comb begin
        logic [ID_W:0] s;
        vld_o = 1'b0;
        idx_o = '0;
        s     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            s = {1'b0, prio_i} + (ID_W+1)'(k);
            if (s >= (ID_W+1)'(N_REQ)) s = s - (ID_W+1)'(N_REQ);
            if (!vld_o && req_i[s[ID_W-1:0]] && !mask_i[s[ID_W-1:0]]) begin
                vld_o = 1'b1;
                idx_o = s[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter sharing one keyed server among N_REQ requesters, with
// per-requester key sequence checking.
module rr_req_arbiter
    import rr_req_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int KEY_W = DEF_KEY_W
) (
    input logic             clk,
    input logic             rst,
    rr_req_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    state_e             state_q;
    logic               srv_req_q;
    logic [KEY_W-1:0]   key_q;
    logic [ID_W-1:0]    id_q, prio_q;
    logic [N_REQ-1:0]   seq_err_q;
    logic [KEY_W-1:0]   exp_q [N_REQ];

    logic               busy_ack, grant, pick_vld;
    logic [ID_W-1:0]    id_inc, pick_prio, pick_idx;
    logic [N_REQ-1:0]   pick_mask;
    logic [KEY_W-1:0]   pick_key;

    // rst gates the ack so an aborted transaction never completes.
    assign busy_ack  = (state_q == BUSY) && bus.srv_ack && !rst;
    assign id_inc    = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;

    // Back-to-back arbitration excludes the current winner: its key is stale.
    assign pick_prio = (state_q == BUSY) ? id_inc : prio_q;
    assign pick_mask = (state_q == BUSY) ? (N_REQ'(1) << id_q) : '0;
    assign grant     = pick_vld && ((state_q == IDLE) || busy_ack);
    assign pick_key  = bus.req_key[pick_idx*KEY_W +: KEY_W];

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i  (bus.req),
        .mask_i (pick_mask),
        .prio_i (pick_prio),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            srv_req_q <= 1'b0;
            key_q     <= '0;
            id_q      <= '0;
            prio_q    <= '0;
            seq_err_q <= '0;
            for (int i = 0; i < N_REQ; i++) exp_q[i] <= '0;
        end else begin
            if (busy_ack) begin
                exp_q[id_q] <= exp_q[id_q] + 1'b1;
                prio_q      <= id_inc;
            end
            if (grant) begin
                state_q   <= BUSY;
                srv_req_q <= 1'b1;
                id_q      <= pick_idx;
                key_q     <= pick_key;
                if (pick_key != exp_q[pick_idx]) seq_err_q[pick_idx] <= 1'b1;
            end else if (busy_ack) begin
                state_q   <= IDLE;
                srv_req_q <= 1'b0;
            end
        end
    end

    assign bus.ack     = busy_ack ? (N_REQ'(1) << id_q) : '0;
    assign bus.srv_req = srv_req_q;
    assign bus.srv_key = key_q;
    assign bus.srv_id  = id_q;
    assign bus.seq_err = seq_err_q;
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: table-driven vectors plus short sequences.
module tb_rr_req_arbiter;
    import rr_req_arbiter_pkg::*;

    logic clk, rst;
    logic auto_key;
    logic [3:0][3:0] tkey;
    logic [15:0] man_key;
    int n_chk, n_err;

    rr_req_arbiter_if #(.N_REQ(4), .KEY_W(4)) bus ();
    rr_req_arbiter #(.N_REQ(4), .KEY_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter-style requesters: each key advances after its ack.
    always @(posedge clk) begin
        if (rst) tkey <= '0;
        else for (int i = 0; i < 4; i++) if (bus.ack[i]) tkey[i] <= 4'(tkey[i] + 1);
    end
    always_comb bus.req_key = auto_key ? tkey : man_key;

    typedef struct {
        logic [3:0] req;
        logic       sack;
        logic       e_req;
        logic [1:0] e_id;
        key_t       e_key;
        logic [3:0] e_ack;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.srv_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        auto_key = 1'b1; man_key = '0;
        vt[0]  = '{4'b1010, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0000};
        vt[1]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'd0, 4'b0000};
        vt[2]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'd0, 4'b0000};
        vt[3]  = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'd0, 4'b0010};
        vt[4]  = '{4'b1010, 1'b0, 1'b1, 2'd3, 4'd0, 4'b0000};
        vt[5]  = '{4'b1010, 1'b0, 1'b1, 2'd3, 4'd0, 4'b0000};
        vt[6]  = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'd0, 4'b1000};
        vt[7]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'd1, 4'b0000};
        vt[8]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'd1, 4'b0000};
        vt[9]  = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'd1, 4'b0010};
        vt[10] = '{4'b1010, 1'b0, 1'b1, 2'd3, 4'd1, 4'b0000};
        vt[11] = '{4'b1010, 1'b0, 1'b1, 2'd3, 4'd1, 4'b0000};
        vt[12] = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'd1, 4'b1000};
        vt[13] = '{4'b0000, 1'b0, 1'b1, 2'd1, 4'd2, 4'b0000};
        vt[14] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'd2, 4'b0010};
        vt[15] = '{4'b0000, 1'b0, 1'b0, 2'd1, 4'd2, 4'b0000};

        do_reset();
        chk("reset srv_req", 32'(bus.srv_req), 0);
        chk("reset srv_key", 32'(bus.srv_key), 0);
        chk("reset srv_id",  32'(bus.srv_id), 0);
        chk("reset seq_err", 32'(bus.seq_err), 0);
        chk("reset ack",     32'(bus.ack), 0);

        // srv_ack while idle with no requests is ignored
        bus.srv_ack = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("idle ack", 32'(bus.ack), 0);
            chk("idle srv_req", 32'(bus.srv_req), 0);
            step();
        end

        // lone requester 0, srv_ack tied high, keys wrap through 15 -> 0
        bus.req = 4'b0001;
        step();
        for (int k = 0; k < 34; k++) begin
            chk("lone srv_req", 32'(bus.srv_req), 32'(k % 2 == 0));
            chk("lone ack", 32'(bus.ack), 32'(k % 2 == 0));
            if (k % 2 == 0) chk("lone srv_key", 32'(bus.srv_key), 32'((k / 2) % 16));
            chk("lone seq_err", 32'(bus.seq_err), 0);
            step();
        end

        // all four requesting, srv_ack every busy cycle
        do_reset();
        bus.req = 4'b1111;
        bus.srv_ack = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            chk("all srv_req", 32'(bus.srv_req), 1);
            chk("all srv_id",  32'(bus.srv_id), 32'(k % 4));
            chk("all srv_key", 32'(bus.srv_key), 32'(k / 4));
            chk("all ack",     32'(bus.ack), 32'(1 << (k % 4)));
            step();
        end
        chk("all seq_err", 32'(bus.seq_err), 0);

        // requesters 1 and 3, srv_ack after 3 busy cycles, then req drop while granted
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.req = vt[k].req;
            bus.srv_ack = vt[k].sack;
            #1;
            chk($sformatf("vec%0d srv_req", k), 32'(bus.srv_req), 32'(vt[k].e_req));
            chk($sformatf("vec%0d srv_id", k),  32'(bus.srv_id), 32'(vt[k].e_id));
            chk($sformatf("vec%0d srv_key", k), 32'(bus.srv_key), 32'(vt[k].e_key));
            chk($sformatf("vec%0d ack", k),     32'(bus.ack), 32'(vt[k].e_ack));
            step();
        end
        chk("vec seq_err", 32'(bus.seq_err), 0);

        // requester 2 presents key 5 while 0 is expected
        do_reset();
        auto_key = 1'b0;
        man_key = 16'h0500;
        bus.req = 4'b0100;
        step();
        chk("seq srv_req", 32'(bus.srv_req), 1);
        chk("seq srv_id",  32'(bus.srv_id), 2);
        chk("seq srv_key", 32'(bus.srv_key), 5);
        chk("seq seq_err", 32'(bus.seq_err), 32'h4);
        bus.srv_ack = 1'b1;
        #1;
        chk("seq ack", 32'(bus.ack), 32'h4);
        step();
        bus.srv_ack = 1'b0;
        bus.req = '0;
        step();
        chk("seq sticky", 32'(bus.seq_err), 32'h4);
        chk("seq idle", 32'(bus.srv_req), 0);

        // reset while busy with srv_ack high
        man_key = 16'h0100;
        bus.req = 4'b0100;
        step();
        chk("rst busy", 32'(bus.srv_req), 1);
        rst = 1'b1;
        bus.srv_ack = 1'b1;
        bus.req = 4'b1100;
        man_key = 16'h0000;
        #1;
        chk("rst ack", 32'(bus.ack), 0);
        step();
        rst = 1'b0;
        bus.srv_ack = 1'b0;
        #1;
        chk("rst srv_req", 32'(bus.srv_req), 0);
        chk("rst seq_err", 32'(bus.seq_err), 0);
        step();
        chk("rst grant req", 32'(bus.srv_req), 1);
        chk("rst grant id",  32'(bus.srv_id), 2);
        chk("rst grant err", 32'(bus.seq_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
